// File: rtl/shiftx_ift_pkg.sv
// Shared types and helpers for the pipelined $shiftx IFT cell.
// Optional statistics counters are enabled with SHIFTX_IFT_STATS_EN.
package shiftx_ift_pkg;

    localparam int T_WIDTH_DEF = 32;
    localparam int STAGES_MAX  = 4;
    localparam int STATS_W     = 16;

    typedef logic [T_WIDTH_DEF-1:0] taint_t;

    typedef struct packed {
        logic signed [31:0] idx;
        logic               ok;
    } src_t;

    // Source bit index for output bit k; 32-bit signed arithmetic never wraps for legal widths.
    function automatic src_t calc_src(input int k, input int b_val, input int a_width);
        src_t r;
        r.idx = k + b_val;
        r.ok  = (r.idx >= 0) && (r.idx < a_width);
        return r;
    endfunction

endpackage

// File: rtl/shiftx_ift_stage.sv
// One elastic valid/ready register slice carrying an opaque payload.
// Loads whenever it is empty or its content is being taken downstream.
module shiftx_ift_stage
    import shiftx_ift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         ARST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = ~valid_reg | out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/shiftx_ift_pipe.sv
// Pipelined $shiftx with taint propagation and out-of-range bit reporting.
// Define SHIFTX_IFT_STATS_EN to add saturating taint_cnt / undef_cnt outputs.
module shiftx_ift_pipe
    import shiftx_ift_pkg::*;
#(
    parameter int A_WIDTH  = 8,
    parameter int B_WIDTH  = 3,
    parameter int Y_WIDTH  = 8,
    parameter int B_SIGNED = 0,
    parameter int T_WIDTH  = 32,
    parameter int STAGES   = 2
) (
    input  logic               CLK,
    input  logic               ARST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [T_WIDTH-1:0] A_t,
    input  logic [T_WIDTH-1:0] B_t,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_WIDTH-1:0] Y,
    output logic [Y_WIDTH-1:0] Y_x,
    output logic [T_WIDTH-1:0] Y_t
`ifdef SHIFTX_IFT_STATS_EN
    ,
    output logic [STATS_W-1:0] taint_cnt,
    output logic [STATS_W-1:0] undef_cnt
`endif
);

    localparam int NSTG = (STAGES < 1) ? 1 : ((STAGES > STAGES_MAX) ? STAGES_MAX : STAGES);
    localparam int DW   = 2 * Y_WIDTH + T_WIDTH;

    logic signed [31:0] b_val;
    logic [Y_WIDTH-1:0] y_c;
    logic [Y_WIDTH-1:0] yx_c;
    logic [T_WIDTH-1:0] yt_c;

    generate
        if (B_SIGNED != 0) begin : g_bsigned
            assign b_val = {{(32-B_WIDTH){B[B_WIDTH-1]}}, B};
        end else begin : g_bunsigned
            assign b_val = {{(32-B_WIDTH){1'b0}}, B};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < Y_WIDTH; gi++) begin : g_bit
            src_t sr;
            logic y_bit;
            assign sr = calc_src(gi, b_val, A_WIDTH);
            always_comb begin
                y_bit = 1'b0;
                for (int j = 0; j < A_WIDTH; j++) begin
                    if (sr.ok && (sr.idx == j)) begin
                        y_bit = A[j];
                    end
                end
            end
            assign y_c[gi]  = y_bit;
            assign yx_c[gi] = ~sr.ok;
        end
    endgenerate

    // A's tag only reaches Y if at least one output bit actually comes from A.
    assign yt_c = B_t | ((&yx_c) ? '0 : A_t);

    logic [NSTG:0] stg_valid;
    logic [NSTG:0] stg_ready;
    logic [DW-1:0] stg_data [0:NSTG];

    assign stg_valid[0]    = in_valid;
    assign stg_data[0]     = {y_c, yx_c, yt_c};
    assign in_ready        = stg_ready[0];
    assign stg_ready[NSTG] = out_ready;

    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            shiftx_ift_stage #(.W(DW)) u_stage (
                .CLK       (CLK),
                .ARST      (ARST),
                .in_valid  (stg_valid[gi]),
                .in_ready  (stg_ready[gi]),
                .in_data   (stg_data[gi]),
                .out_valid (stg_valid[gi+1]),
                .out_ready (stg_ready[gi+1]),
                .out_data  (stg_data[gi+1])
            );
        end
    endgenerate

    assign out_valid = stg_valid[NSTG];
    assign Y         = stg_data[NSTG][DW-1 -: Y_WIDTH];
    assign Y_x       = stg_data[NSTG][T_WIDTH +: Y_WIDTH];
    assign Y_t       = stg_data[NSTG][T_WIDTH-1:0];

`ifdef SHIFTX_IFT_STATS_EN
    logic               out_fire;
    logic [STATS_W-1:0] taint_cnt_reg;
    logic [STATS_W-1:0] undef_cnt_reg;

    assign out_fire  = out_valid & out_ready;
    assign taint_cnt = taint_cnt_reg;
    assign undef_cnt = undef_cnt_reg;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            taint_cnt_reg <= '0;
            undef_cnt_reg <= '0;
        end else if (out_fire) begin
            if ((Y_t != '0) && (taint_cnt_reg != '1)) begin
                taint_cnt_reg <= taint_cnt_reg + 1'b1;
            end
            if ((Y_x != '0) && (undef_cnt_reg != '1)) begin
                undef_cnt_reg <= undef_cnt_reg + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shiftx_ift_pipe.sv
// Scoreboard bench for shiftx_ift_pipe: default, signed-B and narrow-A/Y instances.
module tb_shiftx_ift_pipe;
    import shiftx_ift_pkg::*;

    logic CLK = 1'b0;
    logic ARST = 1'b1;
    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    int exp_taint  = 0;
    int exp_undef  = 0;
    int acc_cnt    = 0;

    typedef logic [47:0] exp_t;   // {y[7:0], yx[7:0], t[31:0]}
    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_n[$];

    // main DUT, default parameters
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] A = '0;
    logic [2:0] B = '0;
    taint_t     A_t = '0, B_t = '0;
    logic       in_ready, out_valid;
    logic [7:0] Y, Y_x;
    taint_t     Y_t;
`ifdef SHIFTX_IFT_STATS_EN
    logic [15:0] taint_cnt, undef_cnt;
`endif

    shiftx_ift_pipe dut (
        .CLK(CLK), .ARST(ARST), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .A_t(A_t), .B_t(B_t),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .Y_x(Y_x), .Y_t(Y_t)
`ifdef SHIFTX_IFT_STATS_EN
        , .taint_cnt(taint_cnt), .undef_cnt(undef_cnt)
`endif
    );

    // signed-B instance
    logic       s_valid = 1'b0;
    logic [7:0] s_A = '0;
    logic [2:0] s_B = '0;
    taint_t     s_At = '0, s_Bt = '0;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_Y, s_Yx;
    taint_t     s_Yt;
`ifdef SHIFTX_IFT_STATS_EN
    logic [15:0] s_tc, s_uc;
`endif

    shiftx_ift_pipe #(.B_SIGNED(1)) dut_s (
        .CLK(CLK), .ARST(ARST), .in_valid(s_valid), .in_ready(s_in_ready),
        .A(s_A), .B(s_B), .A_t(s_At), .B_t(s_Bt),
        .out_valid(s_out_valid), .out_ready(1'b1), .Y(s_Y), .Y_x(s_Yx), .Y_t(s_Yt)
`ifdef SHIFTX_IFT_STATS_EN
        , .taint_cnt(s_tc), .undef_cnt(s_uc)
`endif
    );

    // narrow instance: A_WIDTH=2, Y_WIDTH=4
    logic       n_valid = 1'b0;
    logic [1:0] n_A = '0;
    logic [2:0] n_B = '0;
    taint_t     n_At = '0, n_Bt = '0;
    logic       n_in_ready, n_out_valid;
    logic [3:0] n_Y, n_Yx;
    taint_t     n_Yt;
`ifdef SHIFTX_IFT_STATS_EN
    logic [15:0] n_tc, n_uc;
`endif

    shiftx_ift_pipe #(.A_WIDTH(2), .Y_WIDTH(4)) dut_n (
        .CLK(CLK), .ARST(ARST), .in_valid(n_valid), .in_ready(n_in_ready),
        .A(n_A), .B(n_B), .A_t(n_At), .B_t(n_Bt),
        .out_valid(n_out_valid), .out_ready(1'b1), .Y(n_Y), .Y_x(n_Yx), .Y_t(n_Yt)
`ifdef SHIFTX_IFT_STATS_EN
        , .taint_cnt(n_tc), .undef_cnt(n_uc)
`endif
    );

    task automatic cmp(input string nm, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [47:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: got unexpected output %h want none", nm, act);
    endtask

    task automatic send(input logic [7:0] a, input logic [2:0] b, input taint_t at, input taint_t bt,
                        input logic [7:0] ey, input logic [7:0] eyx, input taint_t et);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        A = a; B = b; A_t = at; B_t = bt; in_valid = 1'b1;
        do begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK);
            t++;
        end while (!acc && t < 200);
        if (acc) begin
            q_m.push_back({ey, eyx, et});
            acc_cnt++;
            $display("IN  a=%h b=%0d at=%h bt=%h", a, b, at, bt);
        end else begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles want accept");
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] a, input logic [2:0] b, input taint_t at, input taint_t bt,
                          input logic [7:0] ey, input logic [7:0] eyx, input taint_t et);
        s_A = a; s_B = b; s_At = at; s_Bt = bt; s_valid = 1'b1;
        @(negedge CLK);
        cmp("s_in_ready", {47'd0, s_in_ready}, 48'd1);
        @(posedge CLK);
        q_s.push_back({ey, eyx, et});
        $display("IN  signed a=%h b=%b", a, b);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_n(input logic [1:0] a, input logic [2:0] b, input taint_t at, input taint_t bt,
                          input logic [3:0] ey, input logic [3:0] eyx, input taint_t et);
        n_A = a; n_B = b; n_At = at; n_Bt = bt; n_valid = 1'b1;
        @(posedge CLK);
        q_n.push_back({4'd0, ey, 4'd0, eyx, et});
        $display("IN  narrow a=%b b=%0d", a, b);
        #1 n_valid = 1'b0;
    endtask

    // main monitor: pop on transfer, check held output against queue head while stalled
    always @(negedge CLK) begin
        if (!ARST && out_valid) begin
            if (q_m.size() == 0) begin
                unexpected("main_out", {Y, Y_x, Y_t});
            end else if (out_ready) begin
                exp_t e;
                e = q_m.pop_front();
                $display("OUT y=%h yx=%h yt=%h", Y, Y_x, Y_t);
                cmp("main_out", {Y, Y_x, Y_t}, e);
                if (e[31:0] != 0) exp_taint++;
                if (e[39:32] != 0) exp_undef++;
            end else begin
                cmp("main_stall_hold", {Y, Y_x, Y_t}, q_m[0]);
            end
        end
    end

    always @(negedge CLK) begin
        if (!ARST && s_out_valid) begin
            if (q_s.size() == 0) unexpected("signed_out", {s_Y, s_Yx, s_Yt});
            else begin
                $display("OUT signed y=%h yx=%h yt=%h", s_Y, s_Yx, s_Yt);
                cmp("signed_out", {s_Y, s_Yx, s_Yt}, q_s.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (!ARST && n_out_valid) begin
            if (q_n.size() == 0) unexpected("narrow_out", {4'd0, n_Y, 4'd0, n_Yx, n_Yt});
            else begin
                $display("OUT narrow y=%h yx=%h yt=%h", n_Y, n_Yx, n_Yt);
                cmp("narrow_out", {4'd0, n_Y, 4'd0, n_Yx, n_Yt}, q_n.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 ARST = 1'b0;
        @(negedge CLK);
        cmp("reset_out_valid", {47'd0, out_valid}, 48'd0);
        cmp("reset_in_ready", {47'd0, in_ready}, 48'd1);
        cmp("reset_outputs", {Y, Y_x, Y_t}, 48'd0);
        @(posedge CLK);
        #1;

        // main function
        send(8'hB4, 3'd3, 32'h1,  32'h0,  8'h16, 8'hE0, 32'h1);
        send(8'hFF, 3'd0, 32'h4,  32'h8,  8'hFF, 8'h00, 32'hC);
        send(8'h5A, 3'd7, 32'h20, 32'h0,  8'h00, 8'hFE, 32'h20);
        send(8'h80, 3'd7, 32'h0,  32'h40, 8'h01, 8'hFE, 32'h40);
        send(8'h0F, 3'd1, 32'h0,  32'h0,  8'h07, 8'h80, 32'h0);

        send_s(8'h81, 3'b111, 32'h100, 32'h2, 8'h02, 8'h01, 32'h102);
        send_s(8'h01, 3'b110, 32'h40,  32'h0, 8'h04, 8'h03, 32'h40);
        send_s(8'h81, 3'b010, 32'h0,   32'h0, 8'h20, 8'hC0, 32'h0);
        send_n(2'b11, 3'd3, 32'hF, 32'h10, 4'h0, 4'hF, 32'h10);
        send_n(2'b10, 3'd1, 32'hF, 32'h10, 4'h1, 4'hE, 32'h1F);
        repeat (4) @(posedge CLK);
        #1;

        // back-pressure: 5 stalled cycles, 4 items offered
        acc_cnt = 0;
        out_ready = 1'b0;
        fork
            begin
                send(8'h11, 3'd1, 32'h1, 32'h0, 8'h08, 8'h80, 32'h1);
                send(8'h33, 3'd4, 32'h2, 32'h0, 8'h03, 8'hF0, 32'h2);
                send(8'h44, 3'd5, 32'h0, 32'h4, 8'h02, 8'hF8, 32'h4);
                send(8'hC3, 3'd2, 32'h8, 32'h0, 8'h30, 8'hC0, 32'h8);
            end
            begin
                repeat (5) @(posedge CLK);
                #1;
                cmp("bp_accepted", 48'(acc_cnt), 48'd2);
                cmp("bp_in_ready", {47'd0, in_ready}, 48'd0);
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge CLK);
                    cmp("bp_drain_rate", {47'd0, out_valid}, 48'd1);
                end
            end
        join
        repeat (4) @(posedge CLK);
        #1;

        // reset with two items in flight
        out_ready = 1'b0;
        send(8'hFF, 3'd0, 32'h1, 32'h0, 8'hFF, 8'h00, 32'h1);
        send(8'hF0, 3'd4, 32'h2, 32'h0, 8'h0F, 8'hF0, 32'h2);
        #2 ARST = 1'b1;
        #1;
        cmp("arst_out_valid", {47'd0, out_valid}, 48'd0);
        cmp("arst_y", {8'd0, Y, Y_t}, 48'd0);
        q_m.delete();
        @(posedge CLK);
        #1 ARST = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        cmp("arst_in_ready", {47'd0, in_ready}, 48'd1);
        repeat (5) @(posedge CLK);
        #1;

        send(8'hB4, 3'd3, 32'h1, 32'h0, 8'h16, 8'hE0, 32'h1);
        repeat (4) @(posedge CLK);
        #1;

`ifdef SHIFTX_IFT_STATS_EN
        cmp("taint_cnt", 48'(taint_cnt), 48'(exp_taint));
        cmp("undef_cnt", 48'(undef_cnt), 48'(exp_undef));
`endif
        cmp("leftover_items", 48'(q_m.size() + q_s.size() + q_n.size()), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
